md_iter_engine: RTL and testbench

Iterative 32-cycle multiply/divide engine for the execute stage. It consumes the operand/opcode bundle that the multiply/divide front end latches when it issues `start`, and returns the HI/LO result after a fixed latency. Unsigned and signed operations both use shift-add multiplication and restoring division on magnitudes, followed by a sign-fix step. The front end and hazard logic use `busy` and `done` to stall mfhi/mflo/mult/div.

---
 rtl/md_iter_engine.sv | 168 ++++++++++++++++
 tb/tb_md_iter_engine.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/md_iter_engine.sv
// Iterative multiply/divide engine: shift-add multiply and restoring divide on
// operand magnitudes, then a sign-fix step. Fixed WIDTH+3 cycle latency.
module md_iter_engine #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               state_r;
  logic [1:0]           op_r;
  logic                 sa_r;
  logic                 sb_r;
  logic [CW-1:0]        cnt_r;
  // Upper half: multiply accumulator / partial remainder.
  // Lower half: multiplier / dividend shifting out while the quotient shifts in.
  logic [2*WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]     opnd_r;

  logic                 lo_neg_s;
  logic                 opnd_neg_s;
  logic [WIDTH-1:0]     lo_mag_s;
  logic [WIDTH-1:0]     opnd_mag_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_next_s;
  logic [WIDTH:0]       div_tmp_s;
  logic                 div_ge_s;
  logic [WIDTH-1:0]     div_diff_s;
  logic [2*WIDTH-1:0]   div_next_s;
  logic [2*WIDTH-1:0]   mul_fix_s;
  logic [WIDTH-1:0]     quo_fix_s;
  logic [WIDTH-1:0]     rem_fix_s;
  logic [WIDTH-1:0]     res_hi_s;
  logic [WIDTH-1:0]     res_lo_s;
  logic                 dbz_s;

  // Operand magnitudes, one iteration step for each algorithm, and sign fix.
  always_comb begin
    lo_neg_s   = op_r[0] & acc_r[WIDTH-1];
    opnd_neg_s = op_r[0] & opnd_r[WIDTH-1];
    lo_mag_s   = lo_neg_s ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    opnd_mag_s = opnd_neg_s ? -opnd_r : opnd_r;

    mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
    div_tmp_s  = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_ge_s   = (div_tmp_s >= {1'b0, opnd_r});
    div_diff_s = div_tmp_s[WIDTH-1:0] - opnd_r;

    if (acc_r[0]) begin
      mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end else begin
      mul_next_s = {1'b0, acc_r[2*WIDTH-1:1]};
    end

    if (div_ge_s) begin
      div_next_s = {div_diff_s, acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {div_tmp_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end

    mul_fix_s = (sa_r ^ sb_r) ? -acc_r : acc_r;
    quo_fix_s = (sa_r ^ sb_r) ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    rem_fix_s = sa_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];

    if (op_r[1]) begin
      res_hi_s = rem_fix_s;
      res_lo_s = quo_fix_s;
    end else begin
      res_hi_s = mul_fix_s[2*WIDTH-1:WIDTH];
      res_lo_s = mul_fix_s[WIDTH-1:0];
    end

    dbz_s = op_r[1] & (opnd_r == {WIDTH{1'b0}});
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      op_r        <= 2'b00;
      sa_r        <= 1'b0;
      sb_r        <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      opnd_r      <= {WIDTH{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= {WIDTH{1'b0}};
      lo          <= {WIDTH{1'b0}};
    end else if (cancel && (state_r != S_IDLE)) begin
      state_r     <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start && !cancel) begin
            op_r    <= op;
            acc_r   <= {{WIDTH{1'b0}}, (op[1] ? a : b)};
            opnd_r  <= op[1] ? b : a;
            busy    <= 1'b1;
            state_r <= S_PREP;
          end
        end
        S_PREP: begin
          sa_r    <= lo_neg_s;
          sb_r    <= opnd_neg_s;
          acc_r   <= {{WIDTH{1'b0}}, lo_mag_s};
          opnd_r  <= opnd_mag_s;
          cnt_r   <= CNT_LOAD;
          state_r <= S_RUN;
        end
        S_RUN: begin
          cnt_r <= cnt_r - CNT_ONE;
          acc_r <= op_r[1] ? div_next_s : mul_next_s;
          if (cnt_r == CNT_ONE) begin
            state_r <= S_FIX;
          end
        end
        S_FIX: begin
          if (!dbz_s) begin
            hi <= res_hi_s;
            lo <= res_lo_s;
          end
          div_by_zero <= dbz_s;
          done        <= 1'b1;
          state_r     <= S_DONE;
        end
        S_DONE: begin
          done        <= 1'b0;
          div_by_zero <= 1'b0;
          busy        <= 1'b0;
          state_r     <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_iter_engine.sv
// Self-checking bench for md_iter_engine: directed cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_md_iter_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        cancel = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m = 32'h0;
  logic [31:0] lo_m = 32'h0;

  md_iter_engine #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: architectural result of each operation; returns 1 for divide by zero.
  function automatic bit model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               inout logic [31:0] rh, inout logic [31:0] rl);
    logic [63:0] up;
    longint sx, sy, sp, sq, sr;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      2'd0: begin up = {32'h0, x} * {32'h0, y}; rh = up[63:32]; rl = up[31:0]; end
      2'd1: begin sp = sx * sy; rh = sp[63:32]; rl = sp[31:0]; end
      2'd2: begin
        if (y == 32'h0) return 1'b1;
        rl = x / y; rh = x % y;
      end
      default: begin
        if (y == 32'h0) return 1'b1;
        sq = sx / sy; sr = sx % sy;
        rl = sq[31:0]; rh = sr[31:0];
      end
    endcase
    return 1'b0;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int cancel_k, input int reset_k,
                        input int extra_k);
    int busy_cnt = 0, done_cnt = 0, done_at = -1, dbz_cnt = 0, dbz_at = -1;
    bit exp_dbz;
    bit aborted;
    aborted = (cancel_k >= 0) || (reset_k >= 0);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 36; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      start = 1'b0; cancel = 1'b0; reset = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_at = k; end
      if (div_by_zero) begin dbz_cnt++; dbz_at = k; end
      if (k == cancel_k) cancel = 1'b1;
      if (k == reset_k) reset = 1'b1;
      if (k == extra_k) begin
        start = 1'b1; op = ~o; a = $urandom; b = $urandom;
      end
    end
    if (reset_k >= 0) begin
      hi_m = 32'h0; lo_m = 32'h0;
      check({tag, " busy cycles"}, 64'(busy_cnt), 64'(reset_k + 1));
    end else if (cancel_k >= 0) begin
      check({tag, " busy cycles"}, 64'(busy_cnt), 64'(cancel_k + 1));
    end else begin
      exp_dbz = model(o, x, y, hi_m, lo_m);
      check({tag, " busy cycles"}, 64'(busy_cnt), 64'd35);
      check({tag, " done cycle"}, 64'(done_at), 64'd34);
      check({tag, " dbz cycle"}, 64'(dbz_at), exp_dbz ? 64'd34 : 64'hFFFF_FFFF_FFFF_FFFF);
    end
    check({tag, " done count"}, 64'(done_cnt), aborted ? 64'd0 : 64'd1);
    check({tag, " dbz count"}, 64'(dbz_cnt), 64'(aborted ? 0 : int'(model(o, x, y, hi_m, lo_m))));
    check({tag, " hi"}, {32'h0, hi}, {32'h0, hi_m});
    check({tag, " lo"}, {32'h0, lo}, {32'h0, lo_m});
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1;
    start = 1'b1;
    cancel = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {63'h0, busy}, 64'd0);
    check("reset done", {63'h0, done}, 64'd0);
    check("reset dbz", {63'h0, div_by_zero}, 64'd0);
    check("reset hi", {32'h0, hi}, 64'd0);
    check("reset lo", {32'h0, lo}, 64'd0);
    reset = 1'b0; start = 1'b0; cancel = 1'b0;

    // start together with cancel in IDLE is ignored
    @(posedge clk); #1;
    start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    check("start+cancel busy", {63'h0, busy}, 64'd0);

    run_op("multu max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1);
    check("multu max hi const", {32'h0, hi}, 64'hFFFF_FFFE);
    check("multu max lo const", {32'h0, lo}, 64'h0000_0001);
    run_op("mult -3*7", 2'd1, 32'hFFFF_FFFD, 32'd7, -1, -1, -1);
    check("mult -3*7 lo const", {32'h0, lo}, 64'hFFFF_FFEB);
    run_op("divu 7/2", 2'd2, 32'd7, 32'd2, -1, -1, -1);
    check("divu 7/2 lo const", {32'h0, lo}, 64'd3);
    run_op("div -7/2", 2'd3, 32'hFFFF_FFF9, 32'd2, -1, -1, -1);
    check("div -7/2 hi const", {32'h0, hi}, 64'hFFFF_FFFF);
    run_op("div overflow", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
    check("div overflow lo const", {32'h0, lo}, 64'h8000_0000);
    run_op("divu preload", 2'd2, 32'h0000_0451, 32'h0000_0020, -1, -1, -1);
    run_op("divu by zero", 2'd2, 32'd5, 32'd0, -1, -1, -1);
    check("dbz hi kept", {32'h0, hi}, 64'h11);
    check("dbz lo kept", {32'h0, lo}, 64'h22);
    run_op("div by zero", 2'd3, 32'hFFFF_0000, 32'd0, -1, -1, -1);
    run_op("cancel run", 2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 10, -1, -1);
    run_op("start while busy", 2'd1, 32'h8765_4321, 32'h0000_1001, -1, -1, 5);
    run_op("reset mid-op", 2'd2, 32'hDEAD_BEEF, 32'd3, -1, 5, -1);
    run_op("multu 3*4", 2'd0, 32'd3, 32'd4, -1, -1, -1);
    check("multu 3*4 lo const", {32'h0, lo}, 64'd12);
    run_op("cancel fix", 2'd3, 32'hFFFF_FF00, 32'd9, 33, -1, -1);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 6 == 5) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      if (i % 4 == 1) ra = {1'b1, 31'($urandom)};
      run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, -1, -1, (i % 5 == 2) ? 20 : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
